// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - receive-side signal bundle between the rx pin path and the byte consumer
// master: the receiver (drives byte/status outputs); slave: the environment (drives rx).
interface serial_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       new_data;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output data,
    output new_data,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  new_data,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 LSB-first UART receiver with centre sampling, glitch rejection and framing check
// All decisions use the double-synchronised rx_s; strobes are registered one-cycle pulses.
module serial_rx #(
  parameter int CLK_PER_BIT = 50
) (
  input  logic         clk,
  input  logic         rst,
  serial_rx_if.master  bus
);

  localparam int CTR_SIZE = $clog2(CLK_PER_BIT);
  localparam logic [CTR_SIZE-1:0] HALF_M1 = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_SIZE-1:0] BIT_M1  = CTR_SIZE'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic                rx_meta, rx_s;
  logic [CTR_SIZE-1:0] ctr, ctr_nx;
  logic [2:0]          bit_ctr, bit_ctr_nx;
  logic [7:0]          shift, shift_nx;
  logic [7:0]          data_q, data_nx;
  logic                new_data_q, new_data_nx;
  logic                frame_err_q, frame_err_nx;

  // Synchroniser resets to the idle (high) level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ctr         <= '0;
      bit_ctr     <= 3'd0;
      shift       <= 8'h00;
      data_q      <= 8'h00;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nx;
      ctr         <= ctr_nx;
      bit_ctr     <= bit_ctr_nx;
      shift       <= shift_nx;
      data_q      <= data_nx;
      new_data_q  <= new_data_nx;
      frame_err_q <= frame_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    ctr_nx       = ctr;
    bit_ctr_nx   = bit_ctr;
    shift_nx     = shift;
    data_nx      = data_q;
    new_data_nx  = 1'b0;
    frame_err_nx = 1'b0;

    case (state)
      IDLE: begin
        ctr_nx     = '0;
        bit_ctr_nx = 3'd0;
        if (!rx_s) state_nx = START;
      end

      // Re-check the line at mid start bit; a high level means it was a glitch.
      START: begin
        if (ctr == HALF_M1) begin
          ctr_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end else begin
          ctr_nx = ctr + 1'b1;
        end
      end

      DATA: begin
        if (ctr == BIT_M1) begin
          ctr_nx            = '0;
          shift_nx[bit_ctr] = rx_s;
          bit_ctr_nx        = bit_ctr + 3'd1;
          if (bit_ctr == 3'd7) state_nx = STOP;
        end else begin
          ctr_nx = ctr + 1'b1;
        end
      end

      // Leaving at mid stop bit leaves half a bit to spot a back-to-back start edge.
      STOP: begin
        if (ctr == BIT_M1) begin
          ctr_nx = '0;
          if (rx_s) begin
            data_nx     = shift;
            new_data_nx = 1'b1;
            state_nx    = IDLE;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = WAIT_HI;
          end
        end else begin
          ctr_nx = ctr + 1'b1;
        end
      end

      // A break (line held low) must return high before a new start is accepted.
      WAIT_HI: begin
        ctr_nx = '0;
        if (rx_s) state_nx = IDLE;
      end

      default: begin
        state_nx   = IDLE;
        ctr_nx     = '0;
        bit_ctr_nx = 3'd0;
      end
    endcase
  end

  assign bus.data      = data_q;
  assign bus.new_data  = new_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != IDLE);

endmodule
